// File: rtl/sd_card_pkg.sv
// sd_card_pkg: shared constants and types for the SD SPI-mode card responder.
package sd_card_pkg;
    localparam logic [5:0] CMD0  = 6'd0;
    localparam logic [5:0] CMD16 = 6'd16;
    localparam logic [5:0] CMD17 = 6'd17;
    localparam logic [5:0] CMD24 = 6'd24;
    localparam logic [5:0] CMD41 = 6'd41;
    localparam logic [5:0] CMD55 = 6'd55;
    localparam logic [5:0] CMD58 = 6'd58;
    localparam int R1_IDLE_BIT    = 0;
    localparam int R1_ILLEGAL_BIT = 2;
    localparam int R1_LEN    = 8;
    localparam int R3_LEN    = 40;
    localparam int FRAME_LEN = 48;
    typedef enum logic [2:0] {ST_IDLE, ST_RECV, ST_CHECK, ST_WAIT_NCR, ST_SEND} state_t;
endpackage

// File: rtl/sd_card_responder_if.sv
// sd_card_responder_if: command/response bus between host (master) and card model (slave).
//   i_cmd_in serial command in; o_rsp_out/o_rsp_oe serial response; o_cmd_valid/o_frame_err
//   frame pulses; o_cmd_index/o_cmd_arg last valid command; o_in_idle/o_block_len card state.
interface sd_card_responder_if;
    logic        i_cmd_in;
    logic        o_rsp_out;
    logic        o_rsp_oe;
    logic        o_cmd_valid;
    logic [5:0]  o_cmd_index;
    logic [31:0] o_cmd_arg;
    logic        o_frame_err;
    logic        o_in_idle;
    logic [31:0] o_block_len;
    modport master (output i_cmd_in, input o_rsp_out, o_rsp_oe, o_cmd_valid, o_cmd_index,
                    o_cmd_arg, o_frame_err, o_in_idle, o_block_len);
    modport slave  (input i_cmd_in, output o_rsp_out, o_rsp_oe, o_cmd_valid, o_cmd_index,
                    o_cmd_arg, o_frame_err, o_in_idle, o_block_len);
endinterface

// File: rtl/sd_card_rsp_shifter.sv
// sd_card_rsp_shifter: MSB-first serializer for R1/R3 responses.
//   i_load latches i_data (left-justified) and i_len; o_bit is idle-high when inactive,
//   o_active marks driven bits, o_done flags the last bit.
module sd_card_rsp_shifter
    import sd_card_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic [R3_LEN-1:0] i_data,
    input  logic [5:0]        i_len,
    output logic              o_bit,
    output logic              o_active,
    output logic              o_done
);
    logic [R3_LEN-1:0] sreg_q, sreg_d;
    logic [5:0]        cnt_q, cnt_d;
    logic              active_q, active_d;

    always_comb begin
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (i_load) begin
            sreg_d   = i_data;
            cnt_d    = i_len;
            active_d = i_len != 6'd0;
        end else if (active_q) begin
            sreg_d   = {sreg_q[R3_LEN-2:0], 1'b1};
            cnt_d    = cnt_q - 6'd1;
            active_d = cnt_q != 6'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sreg_q   <= '1;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign o_bit    = active_q ? sreg_q[R3_LEN-1] : 1'b1;
    assign o_active = active_q;
    assign o_done   = active_q && cnt_q == 6'd1;
endmodule

// File: rtl/sd_card_responder.sv
// sd_card_responder: card-side SD SPI-mode command receiver, decoder and R1/R3 responder.
//   i_clk/i_rst clock and async active-high reset; bus (slave) carries the serial command
//   input, serial response output and the decoded command/card-state observation outputs.
module sd_card_responder
    import sd_card_pkg::*;
#(
    parameter int          NCR_CYCLES        = 2,
    parameter int          INIT_ACMD41_COUNT = 3,
    parameter logic [31:0] OCR               = 32'h40FF8000
)(
    input  logic          i_clk,
    input  logic          i_rst,
    sd_card_responder_if.slave bus
);
    localparam logic [7:0] ACMD_LIMIT = 8'(INIT_ACMD41_COUNT + 1);

    state_t      state_q, state_d;
    logic [47:0] frame_q, frame_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  acmd_cnt_q, acmd_cnt_d;
    logic        app_cmd_q, app_cmd_d;
    logic        in_idle_q, in_idle_d;
    logic        illegal_q, illegal_d;
    logic        r3_q, r3_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        frame_err_q, frame_err_d;
    logic [5:0]  cmd_index_q, cmd_index_d;
    logic [31:0] cmd_arg_q, cmd_arg_d;
    logic [31:0] block_len_q, block_len_d;
    logic [5:0]  idx;
    logic [31:0] arg;
    logic [7:0]  r1;
    logic [R3_LEN-1:0] rsp_data;
    logic [5:0]  rsp_len;
    logic        shift_load, shift_done, shift_active, shift_bit;
    logic        unused_crc;

    assign idx        = frame_q[45:40];
    assign arg        = frame_q[39:8];
    assign unused_crc = ^{frame_q[47], frame_q[7:1]};
    assign shift_load = state_q == ST_WAIT_NCR && cnt_q == 8'd0;

    // Response is built when serialization starts; card state cannot change meanwhile.
    always_comb begin
        r1                 = '0;
        r1[R1_IDLE_BIT]    = in_idle_q;
        r1[R1_ILLEGAL_BIT] = illegal_q;
        rsp_data = r3_q ? {r1, ~in_idle_q, OCR[30:0]} : {r1, 32'h0};
        rsp_len  = r3_q ? 6'(R3_LEN) : 6'(R1_LEN);
    end

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        cnt_d       = cnt_q;
        acmd_cnt_d  = acmd_cnt_q;
        app_cmd_d   = app_cmd_q;
        in_idle_d   = in_idle_q;
        illegal_d   = illegal_q;
        r3_d        = r3_q;
        cmd_valid_d = 1'b0;
        frame_err_d = 1'b0;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        block_len_d = block_len_q;
        case (state_q)
            ST_IDLE: if (!bus.i_cmd_in) begin
                state_d = ST_RECV;
                frame_d = {frame_q[46:0], 1'b0};
                cnt_d   = 8'd1;
            end
            ST_RECV: begin
                frame_d = {frame_q[46:0], bus.i_cmd_in};
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == 8'(FRAME_LEN - 1)) state_d = ST_CHECK;
            end
            ST_CHECK: if (frame_q[46] && frame_q[0]) begin
                state_d     = ST_WAIT_NCR;
                cnt_d       = 8'(NCR_CYCLES - 1);
                cmd_valid_d = 1'b1;
                cmd_index_d = idx;
                cmd_arg_d   = arg;
                app_cmd_d   = idx == CMD55;
                r3_d        = idx == CMD58;
                illegal_d   = 1'b0;
                case (idx)
                    CMD0: begin
                        in_idle_d  = 1'b1;
                        acmd_cnt_d = '0;
                    end
                    CMD41: if (app_cmd_q) begin
                        acmd_cnt_d = acmd_cnt_q == ACMD_LIMIT ? acmd_cnt_q : acmd_cnt_q + 8'd1;
                        in_idle_d  = acmd_cnt_d == ACMD_LIMIT ? 1'b0 : in_idle_q;
                    end else begin
                        illegal_d = 1'b1;
                    end
                    CMD16: if (in_idle_q) illegal_d = 1'b1; else block_len_d = arg;
                    CMD17, CMD24: illegal_d = in_idle_q;
                    CMD55, CMD58: illegal_d = 1'b0;
                    default: illegal_d = 1'b1;
                endcase
            end else begin
                state_d     = ST_IDLE;
                frame_err_d = 1'b1;
            end
            ST_WAIT_NCR: begin
                cnt_d = cnt_q - 8'd1;
                if (shift_load) state_d = ST_SEND;
            end
            ST_SEND: if (shift_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            cnt_q       <= '0;
            acmd_cnt_q  <= '0;
            app_cmd_q   <= 1'b0;
            in_idle_q   <= 1'b1;
            illegal_q   <= 1'b0;
            r3_q        <= 1'b0;
            cmd_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            cmd_index_q <= '0;
            cmd_arg_q   <= '0;
            block_len_q <= 32'd512;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            cnt_q       <= cnt_d;
            acmd_cnt_q  <= acmd_cnt_d;
            app_cmd_q   <= app_cmd_d;
            in_idle_q   <= in_idle_d;
            illegal_q   <= illegal_d;
            r3_q        <= r3_d;
            cmd_valid_q <= cmd_valid_d;
            frame_err_q <= frame_err_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
            block_len_q <= block_len_d;
        end
    end

    sd_card_rsp_shifter u_shifter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (shift_load),
        .i_data   (rsp_data),
        .i_len    (rsp_len),
        .o_bit    (shift_bit),
        .o_active (shift_active),
        .o_done   (shift_done)
    );

    assign bus.o_rsp_out   = shift_bit;
    assign bus.o_rsp_oe    = shift_active;
    assign bus.o_cmd_valid = cmd_valid_q;
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_cmd_index = cmd_index_q;
    assign bus.o_cmd_arg   = cmd_arg_q;
    assign bus.o_in_idle   = in_idle_q;
    assign bus.o_block_len = block_len_q;
endmodule

// File: tb/tb_sd_card_responder.sv
// tb_sd_card_responder: scoreboard bench for sd_card_responder with directed command frames.
module tb_sd_card_responder;
    localparam int NCR = 2;

    typedef struct {
        bit          err;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [39:0] rsp;
        int          len;
        logic        idle;
        logic [31:0] blen;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];

    sd_card_responder_if bus();

    sd_card_responder #(.NCR_CYCLES(NCR), .INIT_ACMD41_COUNT(3), .OCR(32'h40FF8000)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic exp_t r1e(input logic [47:0] f, input logic [7:0] rsp, input logic idle,
                                 input logic [31:0] blen);
        exp_t e;
        e.err = 1'b0; e.idx = f[45:40]; e.arg = f[39:8];
        e.rsp = {32'h0, rsp}; e.len = 8; e.idle = idle; e.blen = blen;
        return e;
    endfunction

    function automatic exp_t r3e(input logic [47:0] f, input logic [39:0] rsp, input logic idle,
                                 input logic [31:0] blen);
        exp_t e;
        e = r1e(f, 8'h0, idle, blen);
        e.rsp = rsp; e.len = 40;
        return e;
    endfunction

    task automatic shift_frame(input logic [47:0] f, input exp_t e);
        exp_q.push_back(e);
        for (int i = 47; i >= 0; i--) begin
            bus.i_cmd_in = f[i];
            @(negedge clk);
        end
        bus.i_cmd_in = 1'b1;
    endtask

    task automatic send(input logic [47:0] f, input exp_t e);
        shift_frame(f, e);
        repeat (60) @(negedge clk);
    endtask

    // Monitor: pops one expectation per frame pulse and checks the serial response.
    initial begin
        exp_t e;
        int gap;
        logic oe_ok;
        logic oe_seen;
        logic [39:0] rsp;
        forever begin
            @(negedge clk);
            if (!rst && (bus.o_cmd_valid || bus.o_frame_err)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_kind", bus.o_frame_err, e.err);
                    check("valid_vs_err", bus.o_cmd_valid & bus.o_frame_err, 0);
                    if (e.err) begin
                        oe_seen = 1'b0;
                        for (int i = 0; i < 10; i++) begin
                            oe_seen |= bus.o_rsp_oe;
                            @(negedge clk);
                        end
                        check("err_no_rsp", oe_seen, 0);
                    end else begin
                        check("cmd_index", bus.o_cmd_index, e.idx);
                        check("cmd_arg", bus.o_cmd_arg, e.arg);
                        check("in_idle", bus.o_in_idle, e.idle);
                        check("block_len", bus.o_block_len, e.blen);
                        gap = 0;
                        while (!bus.o_rsp_oe && gap < 20 && !rst) begin
                            check("ncr_idle_high", bus.o_rsp_out, 1);
                            gap++;
                            @(negedge clk);
                        end
                        if (!rst) begin
                            check("ncr_gap", gap, NCR);
                            oe_ok = 1'b1;
                            rsp = '0;
                            for (int i = 0; i < e.len && !rst; i++) begin
                                oe_ok &= bus.o_rsp_oe;
                                rsp = {rsp[38:0], bus.o_rsp_out};
                                @(negedge clk);
                            end
                            if (!rst) begin
                                check("rsp_oe_held", oe_ok, 1);
                                check("rsp_bits", rsp, e.rsp);
                                check("rsp_end", {bus.o_rsp_oe, bus.o_rsp_out}, 2'b01);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        exp_t bad;
        int w;
        logic [47:0] c0   = 48'h400000000095;
        logic [47:0] c8   = 48'h48000001AA01;
        logic [47:0] c16  = 48'h500000020001;
        logic [47:0] c17  = 48'h510000000001;
        logic [47:0] c41  = 48'h694000000001;
        logic [47:0] c55  = 48'h770000000001;
        logic [47:0] c58  = 48'h7A0000000001;
        bad = r1e(48'h0, 8'h0, 1'b1, 32'd512);
        bad.err = 1'b1;
        bus.i_cmd_in = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rsp", {bus.o_rsp_oe, bus.o_rsp_out}, 2'b01);
        check("rst_pulses", {bus.o_cmd_valid, bus.o_frame_err}, 2'b00);
        check("rst_cmd", {bus.o_cmd_index, bus.o_cmd_arg}, 38'h0);
        check("rst_state", {bus.o_in_idle, bus.o_block_len}, {1'b1, 32'd512});
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(c0,  r1e(c0,  8'h01, 1'b1, 32'd512));
        send(c41, r1e(c41, 8'h05, 1'b1, 32'd512));
        send(c58, r3e(c58, 40'h0140FF8000, 1'b1, 32'd512));
        send(c16, r1e(c16, 8'h05, 1'b1, 32'd512));
        send(48'h000000000001, bad);
        send(c0,  r1e(c0,  8'h01, 1'b1, 32'd512));
        send(c55, r1e(c55, 8'h01, 1'b1, 32'd512));
        send(c17, r1e(c17, 8'h05, 1'b1, 32'd512));
        send(c41, r1e(c41, 8'h05, 1'b1, 32'd512));
        for (int k = 0; k < 3; k++) begin
            send(c55, r1e(c55, 8'h01, 1'b1, 32'd512));
            send(c41, r1e(c41, 8'h01, 1'b1, 32'd512));
        end
        send(c55, r1e(c55, 8'h01, 1'b1, 32'd512));
        send(c41, r1e(c41, 8'h00, 1'b0, 32'd512));
        send(c58, r3e(c58, 40'h00C0FF8000, 1'b0, 32'd512));
        send(c17, r1e(c17, 8'h00, 1'b0, 32'd512));
        send(c8,  r1e(c8,  8'h04, 1'b0, 32'd512));
        send(c16, r1e(c16, 8'h00, 1'b0, 32'h200));
        shift_frame(c58, r3e(c58, 40'h00C0FF8000, 1'b0, 32'h200));
        w = 0;
        while (!bus.o_rsp_oe && w < 20) begin
            w++;
            @(negedge clk);
        end
        check("send_started", bus.o_rsp_oe, 1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_rsp", {bus.o_rsp_oe, bus.o_rsp_out}, 2'b01);
        check("async_rst_idle", bus.o_in_idle, 1);
        check("async_rst_blen", bus.o_block_len, 32'd512);
        check("async_rst_cmd", bus.o_cmd_index, 6'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send(c0, r1e(c0, 8'h01, 1'b1, 32'd512));
        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
